// File: rtl/mux_ts_pkt_buf_pkg.sv
// rtl/mux_ts_pkt_buf_pkg.sv - frame constants and FSM encodings shared by the TS packet buffer
package mux_ts_pkt_buf_pkg;

  localparam int         TS_WORDS = 47;
  localparam logic [7:0] TS_SYNC  = 8'h47;
  localparam int         HDR_BIT  = 32;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_COLLECT = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mux_ts_pkt_fifo.sv
// rtl/mux_ts_pkt_fifo.sv - payload RAM with speculative and committed write pointers
module mux_ts_pkt_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_i,
  input  logic [31:0]         wdata_i,
  input  logic                commit_i,
  input  logic                rollback_i,
  input  logic                rd_i,
  output logic [31:0]         rdata_o,
  output logic [DEPTH_LOG2:0] free_o,
  output logic                empty_o
);
  localparam int PW = DEPTH_LOG2 + 1;

  logic [31:0]   mem_q [2**DEPTH_LOG2];
  logic [PW-1:0] spec_wptr_q;
  logic [PW-1:0] commit_wptr_q;
  logic [PW-1:0] rptr_q;

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[spec_wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

  // commit is raised together with the write of the last word, hence the +1
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_wptr_q   <= '0;
      commit_wptr_q <= '0;
      rptr_q        <= '0;
    end else begin
      if (rollback_i)  spec_wptr_q <= commit_wptr_q;
      else if (wr_i)   spec_wptr_q <= spec_wptr_q + 1'b1;
      if (commit_i)    commit_wptr_q <= spec_wptr_q + 1'b1;
      if (rd_i)        rptr_q <= rptr_q + 1'b1;
    end
  end

  assign rdata_o = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign free_o  = PW'(2**DEPTH_LOG2) - (commit_wptr_q - rptr_q);
  assign empty_o = (commit_wptr_q == rptr_q);

endmodule

// File: rtl/mux_ts_pkt_buf.sv
// rtl/mux_ts_pkt_buf.sv - store-and-forward TS packet buffer with channel sideband
// Defining MUX_TS_STAT_EN adds stat_clr/stat_good/stat_drop counters.
module mux_ts_pkt_buf
  import mux_ts_pkt_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int DESC_LOG2  = 4,
  parameter int CHAN_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32:0]       ts_din,
  input  logic              ts_din_en,
  output logic [31:0]       dout,
  output logic [CHAN_W-1:0] dout_chan,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              drop_pulse
`ifdef MUX_TS_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_good,
  output logic [31:0]       stat_drop
`endif
);
  localparam int         PW       = DEPTH_LOG2 + 1;
  localparam int         DW       = DESC_LOG2 + 1;
  localparam logic [5:0] NWORDS   = 6'(TS_WORDS);
  localparam logic [5:0] LASTW    = 6'(TS_WORDS - 1);

  logic [PW-1:0] free;
  logic          fifo_empty;
  logic [31:0]   rdata;
  logic          wr_en, commit, rollback, pop, load;

  wr_state_e         wr_state_q, wr_state_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [CHAN_W-1:0] wchan_q, wchan_d;
  logic              drop_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [5:0]        rcnt_q, rcnt_d;

  logic [CHAN_W-1:0] desc_q [2**DESC_LOG2];
  logic [DW-1:0]     dwp_q, drp_q;
  logic              desc_full, desc_empty, hdr, admit, accept;

  mux_ts_pkt_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (wr_en),
    .wdata_i   (ts_din[31:0]),
    .commit_i  (commit),
    .rollback_i(rollback),
    .rd_i      (load),
    .rdata_o   (rdata),
    .free_o    (free),
    .empty_o   (fifo_empty)
  );

  assign desc_full  = ((dwp_q - drp_q) == DW'(2**DESC_LOG2));
  assign desc_empty = (dwp_q == drp_q);
  assign hdr        = ts_din[HDR_BIT];
  assign admit      = (free >= PW'(TS_WORDS)) && !desc_full;
  assign accept     = dout_valid && dout_ready;

  always_comb begin
    wr_state_d = wr_state_q;
    wcnt_d     = wcnt_q;
    wchan_d    = wchan_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    drop_d     = 1'b0;
    // a frame cut short by en falling or by an early header is rolled back
    if (wr_state_q == WR_COLLECT && !(ts_din_en && !hdr)) begin
      rollback   = 1'b1;
      drop_d     = 1'b1;
      wr_state_d = WR_IDLE;
    end
    if (ts_din_en && hdr) begin
      if (admit) begin
        wr_state_d = WR_COLLECT;
        wchan_d    = ts_din[CHAN_W-1:0];
        wcnt_d     = '0;
      end else begin
        wr_state_d = WR_DISCARD;
        drop_d     = 1'b1;
      end
    end else if (ts_din_en) begin
      if (wr_state_q == WR_COLLECT) begin
        if (wcnt_q == '0 && ts_din[31:24] != TS_SYNC) begin
          rollback   = 1'b1;
          drop_d     = 1'b1;
          wr_state_d = WR_DISCARD;
        end else begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + 6'd1;
          if (wcnt_q == LASTW) begin
            commit     = 1'b1;
            wr_state_d = WR_IDLE;
          end
        end
      end else begin
        wr_state_d = WR_DISCARD;
      end
    end else if (wr_state_q == WR_DISCARD) begin
      wr_state_d = WR_IDLE;
    end
  end

  // on eop acceptance a pending descriptor is popped directly, keeping the gap to one cycle
  always_comb begin
    rd_state_d = rd_state_q;
    rcnt_d     = rcnt_q;
    pop        = 1'b0;
    load       = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (!desc_empty) begin
          pop        = 1'b1;
          rcnt_d     = '0;
          rd_state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        if (rcnt_q != NWORDS && (!dout_valid || dout_ready) && !fifo_empty) begin
          load   = 1'b1;
          rcnt_d = rcnt_q + 6'd1;
        end else if (accept && dout_eop) begin
          if (!desc_empty) begin
            pop    = 1'b1;
            rcnt_d = '0;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) desc_q[dwp_q[DESC_LOG2-1:0]] <= wchan_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wcnt_q     <= '0;
      wchan_q    <= '0;
      drop_pulse <= 1'b0;
      rd_state_q <= RD_IDLE;
      rcnt_q     <= '0;
      dwp_q      <= '0;
      drp_q      <= '0;
      dout       <= '0;
      dout_chan  <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wcnt_q     <= wcnt_d;
      wchan_q    <= wchan_d;
      drop_pulse <= drop_d;
      rd_state_q <= rd_state_d;
      rcnt_q     <= rcnt_d;
      if (commit) dwp_q <= dwp_q + 1'b1;
      if (pop) begin
        drp_q     <= drp_q + 1'b1;
        dout_chan <= desc_q[drp_q[DESC_LOG2-1:0]];
      end
      if (load) begin
        dout       <= rdata;
        dout_sop   <= (rcnt_q == '0);
        dout_eop   <= (rcnt_q == LASTW);
        dout_valid <= 1'b1;
      end else if (accept) begin
        dout_sop   <= 1'b0;
        dout_eop   <= 1'b0;
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_TS_STAT_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_good <= '0;
      stat_drop <= '0;
    end else begin
      if (commit && stat_good != '1) stat_good <= stat_good + 32'd1;
      if (drop_d && stat_drop != '1) stat_drop <= stat_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_ts_pkt_buf.sv
// tb/tb_mux_ts_pkt_buf.sv - directed self-checking bench for mux_ts_pkt_buf
module tb_mux_ts_pkt_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] ts_din;
  logic        ts_din_en;
  logic [31:0] dout;
  logic [23:0] dout_chan;
  logic        dout_sop, dout_eop, dout_valid, dout_ready, drop_pulse;
`ifdef MUX_TS_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_good, stat_drop;
`endif

  always #5 clk = ~clk;

  mux_ts_pkt_buf dut (
    .clk       (clk),
    .rst       (rst),
    .ts_din    (ts_din),
    .ts_din_en (ts_din_en),
    .dout      (dout),
    .dout_chan (dout_chan),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .drop_pulse(drop_pulse)
`ifdef MUX_TS_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .stat_good (stat_good),
    .stat_drop (stat_drop)
`endif
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          n_drop = 0;
  bit          stall_q = 1'b0;
  logic [57:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [23:0] ch, input logic [31:0] w0, input int n,
                            input bit good, input bit gap);
    tick;
    ts_din_en = 1'b1;
    ts_din    = {1'b1, 8'h00, ch};
    for (int i = 0; i < n; i++) begin
      tick;
      ts_din = {1'b0, w0 + 32'(i)};
      if (good) exp_q.push_back({ch, i == 0, i == 46, w0 + 32'(i)});
    end
    if (gap) begin
      tick;
      ts_din_en = 1'b0;
      ts_din    = '0;
    end
  endtask

  task automatic wait_drain(input int lim, input string tag);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) tick;
    repeat (5) tick;
    check({"drain_", tag}, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: every accepted word must be the next expected one
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("hold_valid", 64'(dout_valid), 64'd1);
      stall_q = dout_valid && !dout_ready;
      if (drop_pulse) n_drop++;
      if (dout_valid && dout_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("extra_word", 64'(dout_valid), 64'd0);
        else check("out_word", {6'd0, dout_chan, dout_sop, dout_eop, dout}, {6'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, o0, k;
    rst = 1'b1; ts_din = '0; ts_din_en = 1'b0; dout_ready = 1'b1;
`ifdef MUX_TS_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) tick;
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_sop", 64'(dout_sop), 64'd0);
    check("rst_eop", 64'(dout_eop), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_chan", 64'(dout_chan), 64'd0);
    check("rst_drop", 64'(drop_pulse), 64'd0);
    rst = 1'b0;
    tick;

    // single good frame and input-to-sop latency
    d0 = n_drop; o0 = n_out;
    send_frame(24'h00012A, 32'h47001F10, 47, 1'b1, 1'b0);
    k = 0;
    do begin
      tick;
      ts_din_en = 1'b0; ts_din = '0;
      k++;
    end while (!(dout_valid && dout_sop) && k < 20);
    check("latency_le3", 64'(k <= 3), 64'd1);
    wait_drain(300, "single");
    check("single_count", 64'(n_out - o0), 64'd47);
    check("single_drops", 64'(n_drop - d0), 64'd0);

    // bad sync byte
    d0 = n_drop; o0 = n_out;
    send_frame(24'h000007, 32'h46000000, 47, 1'b0, 1'b1);
    repeat (10) tick;
    check("badsync_drops", 64'(n_drop - d0), 64'd1);
    check("badsync_out", 64'(n_out - o0), 64'd0);
`ifdef MUX_TS_STAT_EN
    check("stat_drop_1", 64'(stat_drop), 64'd1);
    check("stat_good_1", 64'(stat_good), 64'd1);
`endif

    // truncated frame rolled back, then good chan 5
    d0 = n_drop; o0 = n_out;
    send_frame(24'h000003, 32'h47000000, 20, 1'b0, 1'b1);
    send_frame(24'h000005, 32'h47AA0000, 47, 1'b1, 1'b1);
    wait_drain(300, "rollback");
    check("rollback_drops", 64'(n_drop - d0), 64'd1);
    check("rollback_count", 64'(n_out - o0), 64'd47);

    // fill with ready low: 10 fit, 11 and 12 dropped
    d0 = n_drop; o0 = n_out;
    dout_ready = 1'b0;
    for (int i = 0; i < 12; i++)
      send_frame(24'h000100 + 24'(i), 32'h47000000 + (32'(i) << 16), 47, i < 10, i == 11);
    repeat (10) tick;
    check("fill_drops", 64'(n_drop - d0), 64'd2);
    dout_ready = 1'b1;
    wait_drain(1500, "fill");
    check("fill_count", 64'(n_out - o0), 64'd470);
`ifdef MUX_TS_STAT_EN
    check("stat_good_12", 64'(stat_good), 64'd12);
    check("stat_drop_4", 64'(stat_drop), 64'd4);
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    check("stat_clr_good", 64'(stat_good), 64'd0);
    check("stat_clr_drop", 64'(stat_drop), 64'd0);
`endif

    // random backpressure over three packets
    o0 = n_out;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send_frame(24'h000021 + 24'(i), 32'h47100000 + (32'(i) << 12), 47, 1'b1, i == 2);
      end
      begin
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || i < 200); i++) begin
          tick;
          dout_ready = 1'($urandom_range(0, 1));
        end
        dout_ready = 1'b1;
      end
    join
    wait_drain(300, "random");
    check("random_count", 64'(n_out - o0), 64'd141);

    // reset in the middle of packet 2 of 3
    o0 = n_out;
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_frame(24'h000031 + 24'(i), 32'h47200000 + (32'(i) << 12), 47, 1'b1, i == 2);
    dout_ready = 1'b1;
    for (int i = 0; i < 500 && (n_out - o0) < 67; i++) tick;
    check("rst_mid_reached", 64'(n_out - o0), 64'd67);
    rst = 1'b1;
    exp_q.delete();
    tick;
    rst = 1'b0;
    check("rst_mid_valid", 64'(dout_valid), 64'd0);
    check("rst_mid_sop", 64'(dout_sop), 64'd0);
    check("rst_mid_chan", 64'(dout_chan), 64'd0);
    o0 = n_out;
    repeat (100) tick;
    check("rst_mid_no_out", 64'(n_out - o0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
